wb_load_unit: RTL and testbench

Parametrised writeback-stage load unit. It accepts one load per handshake, issues aligned bus reads, and with `WB_MISALIGN_EN` merges two beats for loads that cross a bus word. It shifts and extends the result, then presents it to the register-file write port through a valid/ready handshake. It sits between the MEM-stage load issue and the WB-stage rd write-mux, and replaces the purely combinational load alignment path.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/ld_extract.sv | 43 ++++
 rtl/wb_load_unit.sv | 151 +++++++++++++++
 tb/tb_wb_load_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback load unit: access sizes, FSM states and a zero word.
package wb_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        RSP0,
        REQ1,
        RSP1,
        DONE
    } ld_state_t;

    localparam int MAX_XLEN = 64;
    // Consumers slice this down to their own XLEN.
    localparam logic [MAX_XLEN-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/ld_extract.sv
// Purpose: pick a B/H/W/D field out of a two-word window at a byte offset and sign/zero-extend it.
// Latency: purely combinational. Backpressure: none, no state.
module ld_extract
    import wb_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  lo,
    input  logic [XLEN-1:0]  hi,
    input  logic [OFF_W-1:0] off,
    input  logic [1:0]       size,
    input  logic             is_unsigned,
    output logic [XLEN-1:0]  data
);

    logic [2*XLEN-1:0] window;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   mask;
    logic              msb;
    int                nbits;

    assign window  = {hi, lo};
    assign shifted = XLEN'(window >> {off, 3'b000});

    always_comb begin
        nbits = 8 << size;
        if (nbits > XLEN) begin
            nbits = XLEN;
        end
        mask = '0;
        msb  = 1'b0;
        for (int i = 0; i < XLEN; i++) begin
            mask[i] = (i < nbits);
            if (i == nbits - 1) begin
                msb = shifted[i];
            end
        end
        // A full-width field has an all-ones mask, so extension is a no-op.
        data = (shifted & mask) | ((msb && !is_unsigned) ? ~mask : '0);
    end

endmodule

// File: rtl/wb_load_unit.sv
// Purpose: writeback load unit; aligned bus reads, optional two-beat merge (WB_MISALIGN_EN), extend to XLEN.
// Latency: 3 cycles accept-to-wb_valid aligned, 5 for two beats, 1 for an erroring load.
// Backpressure: mem_req_valid holds until mem_req_ready; wb_valid holds until wb_ready; req_ready only in IDLE.
module wb_load_unit
    import wb_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [RD_W-1:0] req_rd,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] wb_data,
    output logic [RD_W-1:0] wb_rd,
    output logic            wb_err
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    ld_state_t        state, state_nxt;
    logic [OFF_W-1:0] off_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [RD_W-1:0]  rd_q;
    logic             err_q;
    logic [XLEN-1:0]  lo_q;
    logic [XLEN-1:0]  hi_src;
    logic [XLEN-1:0]  ext_data;
    logic             req_illegal;
    logic             accept_err;
    logic             two_beat;

    assign req_illegal = (XLEN == 32) && (req_size == SZ_D);

`ifdef WB_MISALIGN_EN
    logic [XLEN-1:0]  hi_q;
    logic [OFF_W+1:0] size_bytes;

    assign accept_err = req_illegal;
    assign size_bytes = (OFF_W+2)'(1) << size_q;
    assign two_beat   = ({2'b00, off_q} + size_bytes) > (OFF_W+2)'(NB);
    assign hi_src     = hi_q;
`else
    logic [OFF_W+1:0] req_bytes;
    logic [OFF_W+1:0] req_bmask;
    logic             req_misal;

    assign req_bytes  = (OFF_W+2)'(1) << req_size;
    assign req_bmask  = req_bytes - (OFF_W+2)'(1);
    assign req_misal  = |({2'b00, req_addr[OFF_W-1:0]} & req_bmask);
    assign accept_err = req_illegal | req_misal;
    assign two_beat   = 1'b0;
    assign hi_src     = ZERO_WORD[XLEN-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid)     state_nxt = accept_err ? DONE : REQ0;
            REQ0: if (mem_req_ready) state_nxt = RSP0;
            RSP0: if (mem_rsp_valid) state_nxt = two_beat ? REQ1 : DONE;
`ifdef WB_MISALIGN_EN
            REQ1: if (mem_req_ready) state_nxt = RSP1;
            RSP1: if (mem_rsp_valid) state_nxt = DONE;
`endif
            DONE: if (wb_ready)      state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            off_q        <= '0;
            size_q       <= SZ_B;
            uns_q        <= 1'b0;
            rd_q         <= '0;
            err_q        <= 1'b0;
            lo_q         <= '0;
            mem_req_addr <= '0;
`ifdef WB_MISALIGN_EN
            hi_q         <= '0;
`endif
        end else begin
            if (state == IDLE && req_valid) begin
                off_q        <= req_addr[OFF_W-1:0];
                size_q       <= req_size;
                uns_q        <= req_unsigned;
                rd_q         <= req_rd;
                err_q        <= accept_err;
                lo_q         <= '0;
                mem_req_addr <= {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
`ifdef WB_MISALIGN_EN
                hi_q         <= '0;
`endif
            end
            if (state == RSP0 && mem_rsp_valid) begin
                lo_q <= mem_rsp_data;
                // Second beat address wraps naturally at the top of the address space.
                if (two_beat) begin
                    mem_req_addr <= mem_req_addr + XLEN'(NB);
                end
            end
`ifdef WB_MISALIGN_EN
            if (state == RSP1 && mem_rsp_valid) begin
                hi_q <= mem_rsp_data;
            end
`endif
        end
    end

    ld_extract #(
        .XLEN (XLEN),
        .OFF_W(OFF_W)
    ) u_extract (
        .lo         (lo_q),
        .hi         (hi_src),
        .off        (off_q),
        .size       (size_q),
        .is_unsigned(uns_q),
        .data       (ext_data)
    );

    assign req_ready     = (state == IDLE);
    assign mem_req_valid = (state == REQ0) || (state == REQ1);
    assign wb_valid      = (state == DONE);
    assign wb_err        = (state == DONE) && err_q;
    assign wb_data       = ((state == DONE) && !err_q) ? ext_data : '0;
    assign wb_rd         = rd_q;

endmodule

// File: tb/tb_wb_load_unit.sv
// Bench for wb_load_unit (XLEN=64): directed table, backpressure/reset sequences, random loads vs a byte-level model.
module tb_wb_load_unit;

    localparam int XLEN = 64;
    localparam int RD_W = 5;
    localparam int NB   = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [XLEN-1:0] req_addr = '0;
    logic [1:0]      req_size = '0;
    logic            req_unsigned = 1'b0;
    logic [RD_W-1:0] req_rd = '0;
    logic            mem_req_valid;
    logic            mem_req_ready = 1'b1;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_rsp_valid = 1'b0;
    logic [XLEN-1:0] mem_rsp_data = '0;
    logic            wb_valid;
    logic            wb_ready = 1'b0;
    logic [XLEN-1:0] wb_data;
    logic [RD_W-1:0] wb_rd;
    logic            wb_err;

    always #5 clk = ~clk;

    wb_load_unit #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_rd(req_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd), .wb_err(wb_err)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [63:0] mem_ovr [logic [63:0]];
    logic [63:0] req_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return {a[31:0] ^ 32'hA5A5_1234, ~a[31:0] + 32'h9E37_79B9};
    endfunction

    function automatic logic [7:0] byte_at(input logic [63:0] b);
        logic [63:0] w;
        w = mem_word({b[63:3], 3'b000});
        return 8'(w >> (8 * int'(b[2:0])));
    endfunction

    // Reference: gather the addressed bytes little-endian, then extend.
    task automatic model(input logic [63:0] addr, input logic [1:0] size, input bit uns,
                         output bit err, output logic [63:0] data, output int beats);
        int nbytes, off;
        nbytes = 1 << size;
        off    = int'(addr[2:0]);
        err    = 1'b0;
        data   = '0;
        beats  = 0;
`ifndef WB_MISALIGN_EN
        if (off % nbytes != 0) err = 1'b1;
`endif
        if (!err) begin
            beats = (off + nbytes > NB) ? 2 : 1;
            for (int i = 0; i < nbytes; i++)
                data = data | (64'(byte_at(addr + 64'(i))) << (8 * i));
            if (!uns && nbytes < 8 && data[8 * nbytes - 1])
                data = data | ~((64'd1 << (8 * nbytes)) - 64'd1);
        end
    endtask

    // One clock; also plays the zero-wait bus responder and checks request stability.
    task automatic tick();
        bit          hs, hold;
        logic [63:0] a;
        hs   = mem_req_valid && mem_req_ready;
        hold = mem_req_valid && !mem_req_ready && rst;
        a    = mem_req_addr;
        @(posedge clk);
        @(negedge clk);
        if (hs) req_q.push_back(a);
        mem_rsp_valid = hs;
        mem_rsp_data  = hs ? mem_word(a) : {$urandom, $urandom};
        if (hold) begin
            chk("mem_req_valid_hold", 64'(mem_req_valid), 64'd1);
            chk("mem_req_addr_hold", mem_req_addr, a);
        end
    endtask

    task automatic run_load(input logic [63:0] addr, input logic [1:0] size, input bit uns,
                            input logic [4:0] rd, input logic [63:0] exp_data, input bit exp_err,
                            input int exp_beats, input int mrdy_hold, input bit mrdy_rand,
                            input int wstall);
        int          lat, held;
        logic [63:0] a0;
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_q.delete();
        req_valid = 1'b1; req_addr = addr; req_size = size; req_unsigned = uns; req_rd = rd;
        tick();
        req_valid = 1'b0; req_addr = {$urandom, $urandom};
        lat = 1; held = 0;
        while (!wb_valid && lat < 64) begin
            if (mem_req_valid && held < mrdy_hold) begin
                mem_req_ready = 1'b0;
                held++;
            end else begin
                mem_req_ready = mrdy_rand ? 1'($urandom_range(1)) : 1'b1;
            end
            tick();
            lat++;
        end
        chk("wb_valid_seen", 64'(wb_valid), 64'd1);
        if (!wb_valid) return;
        if (mrdy_hold == 0 && !mrdy_rand)
            chk("latency", 64'(lat), exp_err ? 64'd1 : 64'(1 + 2 * exp_beats));
        for (int s = 0; s < wstall; s++) begin
            wb_ready = 1'b0;
            tick();
            chk("stall_wb_valid", 64'(wb_valid), 64'd1);
            chk("stall_req_ready", 64'(req_ready), 64'd0);
            chk("stall_wb_data", wb_data, exp_data);
            chk("stall_wb_rd", 64'(wb_rd), 64'(rd));
        end
        chk("wb_err", 64'(wb_err), 64'(exp_err));
        chk("wb_data", wb_data, exp_data);
        chk("wb_rd", 64'(wb_rd), 64'(rd));
        chk("bus_req_count", 64'(req_q.size()), 64'(exp_beats));
        a0 = {addr[63:3], 3'b000};
        if (exp_beats >= 1 && req_q.size() >= 1) chk("bus_addr0", req_q[0], a0);
        if (exp_beats == 2 && req_q.size() >= 2) chk("bus_addr1", req_q[1], a0 + 64'd8);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        mem_req_ready = 1'b1;
        chk("wb_valid_drop", 64'(wb_valid), 64'd0);
    endtask

    typedef struct {
        logic [63:0] addr;
        logic [1:0]  size;
        bit          uns;
        logic [63:0] w0, w1;
        logic [63:0] d_on;
        bit          e_on;
        int          b_on;
        logic [63:0] d_off;
        bit          e_off;
    } vec_t;

    initial begin
        vec_t        tbl [14];
        logic [63:0] d, a;
        bit          e;
        int          b;
        logic [1:0]  sz;

        tbl[0]  = '{64'h1003, 2'd0, 1'b0, 64'h0000_0000_8000_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0};
        tbl[1]  = '{64'h2006, 2'd1, 1'b1, 64'hBEEF_0000_0000_0000, 64'h0, 64'h0000_0000_0000_BEEF, 1'b0, 1, 64'h0000_0000_0000_BEEF, 1'b0};
        tbl[2]  = '{64'h100E, 2'd2, 1'b0, 64'hAABB_0000_0000_0000, 64'h0000_0000_0000_CCDD, 64'hFFFF_FFFF_CCDD_AABB, 1'b0, 2, 64'h0, 1'b1};
        tbl[3]  = '{64'h1004, 2'd3, 1'b0, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h7777_8888_1111_2222, 1'b0, 2, 64'h0, 1'b1};
        tbl[4]  = '{64'h0, 2'd3, 1'b0, 64'h1234, 64'h0, 64'h1234, 1'b0, 1, 64'h1234, 1'b0};
        tbl[5]  = '{64'h3004, 2'd2, 1'b1, 64'h8765_4321_0000_0000, 64'h0, 64'h0000_0000_8765_4321, 1'b0, 1, 64'h0000_0000_8765_4321, 1'b0};
        tbl[6]  = '{64'h3004, 2'd2, 1'b0, 64'h8765_4321_0000_0000, 64'h0, 64'hFFFF_FFFF_8765_4321, 1'b0, 1, 64'hFFFF_FFFF_8765_4321, 1'b0};
        tbl[7]  = '{64'h3002, 2'd1, 1'b0, 64'h0000_0000_8001_0000, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 1, 64'hFFFF_FFFF_FFFF_8001, 1'b0};
        tbl[8]  = '{64'h3007, 2'd0, 1'b1, 64'hF000_0000_0000_0000, 64'h0, 64'h0000_0000_0000_00F0, 1'b0, 1, 64'h0000_0000_0000_00F0, 1'b0};
        tbl[9]  = '{64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 1'b0, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00CD, 64'hFFFF_FFFF_FFFF_CDAB, 1'b0, 2, 64'h0, 1'b1};
        tbl[10] = '{64'h5000, 2'd3, 1'b1, 64'h8000_0000_0000_0001, 64'h0, 64'h8000_0000_0000_0001, 1'b0, 1, 64'h8000_0000_0000_0001, 1'b0};
        tbl[11] = '{64'h4007, 2'd0, 1'b0, 64'h7F00_0000_0000_0000, 64'h0, 64'h0000_0000_0000_007F, 1'b0, 1, 64'h0000_0000_0000_007F, 1'b0};
        tbl[12] = '{64'h6001, 2'd0, 1'b0, 64'h0000_0000_0000_FF00, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        tbl[13] = '{64'h6001, 2'd1, 1'b0, 64'h0000_0000_00BE_EF00, 64'h0, 64'hFFFF_FFFF_FFFF_BEEF, 1'b0, 1, 64'h0, 1'b1};

        // Reset state
        tick(); tick();
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_mem_req_addr", mem_req_addr, 64'd0);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        chk("rst_wb_rd", 64'(wb_rd), 64'd0);
        chk("rst_wb_err", 64'(wb_err), 64'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            a = {tbl[i].addr[63:3], 3'b000};
            mem_ovr[a] = tbl[i].w0;
            mem_ovr[a + 64'd8] = tbl[i].w1;
`ifdef WB_MISALIGN_EN
            run_load(tbl[i].addr, tbl[i].size, tbl[i].uns, 5'(i + 1), tbl[i].d_on, tbl[i].e_on,
                     tbl[i].e_on ? 0 : tbl[i].b_on, 0, 1'b0, 0);
`else
            run_load(tbl[i].addr, tbl[i].size, tbl[i].uns, 5'(i + 1), tbl[i].d_off, tbl[i].e_off,
                     tbl[i].e_off ? 0 : 1, 0, 1'b0, 0);
`endif
        end

        // Backpressure on an aligned LD: request held 3 cycles, result held 4 cycles.
        mem_ovr[64'h7000] = 64'hDEAD_BEEF_0123_4567;
        run_load(64'h7000, 2'd3, 1'b0, 5'd17, 64'hDEAD_BEEF_0123_4567, 1'b0, 1, 3, 1'b0, 4);

        // A stray response while idle must be ignored.
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'hFFFF_0000_FFFF_0000;
        tick();
        chk("stray_rsp_req_ready", 64'(req_ready), 64'd1);
        chk("stray_rsp_wb_valid", 64'(wb_valid), 64'd0);

        // Reset while waiting for the response, then a clean LD at 0x0.
        req_valid = 1'b1; req_addr = 64'h40; req_size = 2'd3; req_unsigned = 1'b0; req_rd = 5'd9;
        tick();
        req_valid = 1'b0;
        tick();
        chk("pre_rst_waiting", 64'({req_ready, mem_req_valid, wb_valid}), 64'd0);
        rst = 1'b0;
        mem_rsp_valid = 1'b0;
        tick();
        chk("rst_mid_req_ready", 64'(req_ready), 64'd1);
        chk("rst_mid_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_mid_wb_rd", 64'(wb_rd), 64'd0);
        rst = 1'b1;
        mem_ovr[64'h0] = 64'h1234;
        run_load(64'h0, 2'd3, 1'b0, 5'd7, 64'h1234, 1'b0, 1, 0, 1'b0, 0);

        // Random loads against the byte-level model.
        for (int n = 0; n < 150; n++) begin
            a  = {$urandom, $urandom};
            sz = 2'($urandom_range(3));
            if ($urandom_range(1) == 1) a = a & ~((64'd1 << sz) - 64'd1);
            if ($urandom_range(3) == 0) a = {61'h1FFF_FFFF_FFFF_FFFF, a[2:0]};
            model(a, sz, 1'($urandom_range(1)), e, d, b);
            req_unsigned = 1'b0;
            begin
                bit u;
                u = 1'($urandom_range(1));
                model(a, sz, u, e, d, b);
                run_load(a, sz, u, 5'($urandom_range(31)), d, e, b, 0,
                         1'($urandom_range(1)), $urandom_range(2));
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
